// File: rtl/riscv_muldiv_seq_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package riscv_muldiv_seq_pkg;

  localparam int unsigned ALU_OP_LEN = 4;
  localparam logic [ALU_OP_LEN-1:0] ALU_OP_ADD = 4'd0;
  localparam logic [ALU_OP_LEN-1:0] ALU_OP_SUB = 4'd1;

  localparam int unsigned MD_OP_LEN = 3;

  // Encodings equal the instruction funct3 field.
  typedef enum logic [MD_OP_LEN-1:0] {
    MdOpMul    = 3'd0,
    MdOpMulh   = 3'd1,
    MdOpMulhsu = 3'd2,
    MdOpMulhu  = 3'd3,
    MdOpDiv    = 3'd4,
    MdOpDivu   = 3'd5,
    MdOpRem    = 3'd6,
    MdOpRemu   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIter = 2'd1,
    StDone = 2'd2
  } md_state_e;

  function automatic logic md_is_div(input logic [MD_OP_LEN-1:0] op);
    return op[2];
  endfunction

  function automatic logic md_is_signed_div(input logic [MD_OP_LEN-1:0] op);
    return op[2] & ~op[0];
  endfunction

endpackage

// File: rtl/riscv_muldiv_seq_if.sv
// Request/response handshake plus the borrowed-ALU port of the mul/div sequencer.
interface riscv_muldiv_seq_if
  import riscv_muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
);
  logic                  start;
  logic                  ready;
  logic [MD_OP_LEN-1:0]  md_op;
  logic [XLEN-1:0]       operand_1;
  logic [XLEN-1:0]       operand_2;
  logic                  flush;
  logic [XLEN-1:0]       result;
  logic                  done;
  logic                  alu_own;
  logic [ALU_OP_LEN-1:0] alu_op;
  logic [XLEN-1:0]       alu_operand_1;
  logic [XLEN-1:0]       alu_operand_2;
  logic [XLEN-1:0]       alu_result;

  modport master (
    output start, md_op, operand_1, operand_2, flush, alu_result,
    input  ready, result, done, alu_own, alu_op, alu_operand_1, alu_operand_2
  );

  modport slave (
    input  start, md_op, operand_1, operand_2, flush, alu_result,
    output ready, result, done, alu_own, alu_op, alu_operand_1, alu_operand_2
  );
endinterface

// File: rtl/riscv_muldiv_seq.sv
// Multi-cycle RV32M sequencer: shift-add multiply and restoring divide, one borrowed
// ALU add/sub per cycle while alu_own is high.
module riscv_muldiv_seq
  import riscv_muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ITERS = 32
) (
  input logic               clk,
  input logic               rst,
  riscv_muldiv_seq_if.slave md
);

  localparam int unsigned CntW = $clog2(ITERS);
  localparam logic [CntW-1:0] LastIter = CntW'(ITERS - 1);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  function automatic logic [2*XLEN-1:0] neg_wide(input logic [2*XLEN-1:0] v);
    return ~v + (2*XLEN)'(1);
  endfunction

  md_state_e       state_q, state_d;
  md_op_e          op_q, op_d, op_in;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d, result_q, result_d;
  logic            neg_q, neg_d, spec_q, spec_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic              accept, special, div_zero, div_ovf, neg_in;
  logic              div_s_hi, div_take, mul_carry;
  logic [XLEN-1:0]   abs_1, abs_2, a_in, b_in, spec_val, div_s_lo, mul_addend, final_res;
  logic [2*XLEN-1:0] prod;

  assign op_in  = md_op_e'(md.md_op);
  assign accept = (state_q == StIdle) && md.start && !md.flush;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (md.flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (md.start) state_d = special ? StDone : StIter;
        StIter:  if (cnt_q == LastIter) state_d = StDone;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Operand conditioning on accept: magnitudes, result sign, and the no-iterate cases.
  always_comb begin
    abs_1  = md.operand_1[XLEN-1] ? neg(md.operand_1) : md.operand_1;
    abs_2  = md.operand_2[XLEN-1] ? neg(md.operand_2) : md.operand_2;
    a_in   = md.operand_1;
    b_in   = md.operand_2;
    neg_in = 1'b0;
    unique case (op_in)
      MdOpMulh, MdOpDiv: begin
        a_in   = abs_1;
        b_in   = abs_2;
        neg_in = md.operand_1[XLEN-1] ^ md.operand_2[XLEN-1];
      end
      MdOpMulhsu: begin
        a_in   = abs_1;
        neg_in = md.operand_1[XLEN-1];
      end
      MdOpRem: begin
        a_in   = abs_1;
        b_in   = abs_2;
        neg_in = md.operand_1[XLEN-1];
      end
      default: ;
    endcase
    div_zero = md_is_div(md.md_op) && (md.operand_2 == '0);
    div_ovf  = md_is_signed_div(md.md_op) && (md.operand_1 == MinNeg) && (md.operand_2 == '1);
    special  = div_zero | div_ovf;
    // md_op[1] distinguishes REM* from DIV* within the divide group.
    if (div_zero) spec_val = md.md_op[1] ? md.operand_1 : '1;
    else          spec_val = md.md_op[1] ? '0 : MinNeg;
  end

  assign {div_s_hi, div_s_lo} = {hi_q, lo_q[XLEN-1]};
  assign div_take   = div_s_hi | (div_s_lo >= dvs_q);
  assign mul_addend = lo_q[0] ? dvs_q : '0;
  assign mul_carry  = md.alu_result < hi_q;

  // Sign fix-up and result selection, evaluated while in DONE.
  always_comb begin
    prod      = neg_q ? neg_wide({hi_q, lo_q}) : {hi_q, lo_q};
    final_res = lo_q;
    unique case (op_q)
      MdOpMul:             final_res = lo_q;
      MdOpMulh, MdOpMulhsu: final_res = prod[2*XLEN-1:XLEN];
      MdOpMulhu:           final_res = hi_q;
      MdOpDiv, MdOpDivu:   final_res = neg_q ? neg(lo_q) : lo_q;
      MdOpRem, MdOpRemu:   final_res = neg_q ? neg(hi_q) : hi_q;
      default:             final_res = lo_q;
    endcase
    if (spec_q) final_res = hi_q;
  end

  always_comb begin
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dvs_d    = dvs_q;
    neg_d    = neg_q;
    spec_d   = spec_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (accept) begin
      op_d   = op_in;
      hi_d   = special ? spec_val : '0;
      lo_d   = a_in;
      dvs_d  = b_in;
      neg_d  = neg_in;
      spec_d = special;
      cnt_d  = '0;
    end else if (state_q == StIter && !md.flush) begin
      cnt_d = cnt_q + CntW'(1);
      if (md_is_div(op_q)) begin
        hi_d = div_take ? md.alu_result : div_s_lo;
        lo_d = {lo_q[XLEN-2:0], div_take};
      end else begin
        hi_d = {mul_carry, md.alu_result[XLEN-1:1]};
        lo_d = {md.alu_result[0], lo_q[XLEN-1:1]};
      end
    end
    if (state_q == StDone) result_d = final_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= MdOpMul;
      hi_q     <= '0;
      lo_q     <= '0;
      dvs_q    <= '0;
      neg_q    <= 1'b0;
      spec_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dvs_q    <= dvs_d;
      neg_q    <= neg_d;
      spec_q   <= spec_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Outputs.
  always_comb begin
    md.ready         = (state_q == StIdle);
    md.done          = (state_q == StDone);
    md.alu_own       = (state_q == StIter);
    md.result        = (state_q == StDone) ? final_res : result_q;
    md.alu_op        = ALU_OP_ADD;
    md.alu_operand_1 = '0;
    md.alu_operand_2 = '0;
    if (state_q == StIter) begin
      if (md_is_div(op_q)) begin
        md.alu_op        = ALU_OP_SUB;
        md.alu_operand_1 = div_s_lo;
        md.alu_operand_2 = dvs_q;
      end else begin
        md.alu_operand_1 = hi_q;
        md.alu_operand_2 = mul_addend;
      end
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_seq.sv
// Self-checking bench for riscv_muldiv_seq: arithmetic reference model, per-cycle
// output checks, and directed vectors with literal expectations.
module tb_riscv_muldiv_seq;
  import riscv_muldiv_seq_pkg::*;

  localparam logic [2:0] OpMul = 3'd0, OpMulh = 3'd1, OpMulhsu = 3'd2, OpMulhu = 3'd3;
  localparam logic [2:0] OpDiv = 3'd4, OpDivu = 3'd5, OpRem = 3'd6, OpRemu = 3'd7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_muldiv_seq_if #(.XLEN(32)) md_if ();

  // Combinational ALU the sequencer borrows.
  assign md_if.alu_result = (md_if.alu_op == ALU_OP_SUB)
                          ? md_if.alu_operand_1 - md_if.alu_operand_2
                          : md_if.alu_operand_1 + md_if.alu_operand_2;

  riscv_muldiv_seq #(.XLEN(32), .ITERS(32)) dut (
    .clk (clk),
    .rst (rst),
    .md  (md_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum {MIdle, MBusy, MDone} m_state_e;
  m_state_e    m_state = MIdle;
  int          m_left  = 0;
  logic [31:0] m_res   = '0;
  logic [31:0] m_hold  = '0;
  logic [2:0]  m_op    = '0;

  logic        s_ready, s_done, s_own;
  logic [31:0] s_result, s_a1, s_a2;
  logic [3:0]  s_op;

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (op)
      OpMul:    begin p = ua * ub; r = p[31:0];  end
      OpMulh:   begin p = sa * sb; r = p[63:32]; end
      OpMulhsu: begin p = sa * ub; r = p[63:32]; end
      OpMulhu:  begin p = ua * ub; r = p[63:32]; end
      OpDiv: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      OpDivu: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin p = ua / ub; r = p[31:0]; end
      end
      OpRem: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (b == 0) r = a;
        else begin p = ua % ub; r = p[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic logic ref_special(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    logic is_div;
    is_div = (op == OpDiv) || (op == OpDivu) || (op == OpRem) || (op == OpRemu);
    return is_div && ((b == 0) ||
           ((op == OpDiv || op == OpRem) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One cycle: sample and compare at the falling edge, advance the model, then return
  // just after the next rising edge where inputs may be changed.
  task automatic tick();
    logic is_div_op;
    @(negedge clk);
    s_ready  = md_if.ready;
    s_done   = md_if.done;
    s_own    = md_if.alu_own;
    s_result = md_if.result;
    s_op     = md_if.alu_op;
    s_a1     = md_if.alu_operand_1;
    s_a2     = md_if.alu_operand_2;
    check("ready", {31'd0, s_ready}, {31'd0, m_state == MIdle});
    check("done", {31'd0, s_done}, {31'd0, m_state == MDone});
    check("alu_own", {31'd0, s_own}, {31'd0, m_state == MBusy});
    check("result", s_result, (m_state == MDone) ? m_res : m_hold);
    if (m_state == MBusy) begin
      is_div_op = (m_op >= OpDiv);
      check("alu_op_busy", {28'd0, s_op}, {28'd0, is_div_op ? ALU_OP_SUB : ALU_OP_ADD});
    end else begin
      check("alu_op_idle", {28'd0, s_op}, {28'd0, ALU_OP_ADD});
      check("alu_opnds_idle", s_a1 | s_a2, 32'd0);
    end
    if (rst) begin
      m_state = MIdle;
      m_hold  = '0;
    end else begin
      if (m_state == MDone) m_hold = m_res;
      if (md_if.flush) begin
        m_state = MIdle;
      end else begin
        case (m_state)
          MIdle: if (md_if.start) begin
            m_op  = md_if.md_op;
            m_res = ref_md(md_if.md_op, md_if.operand_1, md_if.operand_2);
            if (ref_special(md_if.md_op, md_if.operand_1, md_if.operand_2)) begin
              m_state = MDone;
            end else begin
              m_state = MBusy;
              m_left  = 32;
            end
          end
          MBusy: begin
            m_left--;
            if (m_left == 0) m_state = MDone;
          end
          default: m_state = MIdle;
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit hold);
    int lat, own;
    bit got;
    logic [31:0] res;
    md_if.start     = 1'b1;
    md_if.md_op     = op;
    md_if.operand_1 = a;
    md_if.operand_2 = b;
    tick();
    if (hold) begin
      md_if.md_op     = OpMul;
      md_if.operand_1 = 32'hDEAD_BEEF;
      md_if.operand_2 = 32'h1234_5678;
    end else begin
      md_if.start = 1'b0;
    end
    lat = 0;
    own = 0;
    got = 1'b0;
    res = '0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (hold && lat == 32) md_if.start = 1'b0;
      tick();
      lat++;
      if (s_own) own++;
      if (s_done) begin
        got = 1'b1;
        res = s_result;
      end
    end
    md_if.start = 1'b0;
    check({name, "_done_seen"}, {31'd0, got}, 32'd1);
    check({name, "_result"}, res, exp);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_own_cycles"}, own, (exp_lat == 1) ? 0 : 32);
  endtask

  initial begin
    rst             = 1'b1;
    md_if.start     = 1'b0;
    md_if.flush     = 1'b0;
    md_if.md_op     = '0;
    md_if.operand_1 = '0;
    md_if.operand_2 = '0;
    tick();
    tick();
    check("reset_result", s_result, 32'd0);
    check("reset_ready", {31'd0, s_ready}, 32'd1);
    rst = 1'b0;
    tick();

    run_op("mul_7x6", OpMul, 32'd7, 32'd6, 32'd42, 33, 1'b0);
    run_op("mulhu_ff", OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
    run_op("mulh_ff", OpMulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0);
    run_op("mulhsu_m1x2", OpMulhsu, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("mulh_min", OpMulh, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0);
    run_op("mulhsu_min", OpMulhsu, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b0);
    run_op("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
    run_op("rem_m7_2", OpRem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("divu_100_7", OpDivu, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    run_op("remu_100_7", OpRemu, 32'd100, 32'd7, 32'd2, 33, 1'b0);
    run_op("rem_7_m3", OpRem, 32'd7, 32'hFFFF_FFFD, 32'd1, 33, 1'b0);
    run_op("div_min_2", OpDiv, 32'h8000_0000, 32'd2, 32'hC000_0000, 33, 1'b0);
    run_op("divu_max_1", OpDivu, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("divu_by0", OpDivu, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("rem_by0", OpRem, 32'd5, 32'd0, 32'd5, 1, 1'b0);
    run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    run_op("rem_ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
    run_op("divu_held", OpDivu, 32'd100, 32'd7, 32'd14, 33, 1'b1);

    // Abort in the middle of a multiply, then make sure the unit still works.
    md_if.start     = 1'b1;
    md_if.md_op     = OpMul;
    md_if.operand_1 = 32'h0000_1234;
    md_if.operand_2 = 32'h0000_5678;
    tick();
    md_if.start = 1'b0;
    repeat (10) tick();
    md_if.flush = 1'b1;
    tick();
    md_if.flush = 1'b0;
    tick();
    check("flush_ready", {31'd0, s_ready}, 32'd1);
    check("flush_no_done", {31'd0, s_done}, 32'd0);
    check("flush_own", {31'd0, s_own}, 32'd0);
    run_op("mul_3x3", OpMul, 32'd3, 32'd3, 32'd9, 33, 1'b0);

    // Flush coinciding with start drops the request.
    md_if.start = 1'b1;
    md_if.flush = 1'b1;
    tick();
    md_if.start = 1'b0;
    md_if.flush = 1'b0;
    tick();
    check("flush_start_dropped", {31'd0, s_own}, 32'd0);
    check("flush_start_ready", {31'd0, s_ready}, 32'd1);

    // Reset in the middle of a divide.
    md_if.start     = 1'b1;
    md_if.md_op     = OpDiv;
    md_if.operand_1 = 32'd1000;
    md_if.operand_2 = 32'd7;
    tick();
    md_if.start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rst_ready", {31'd0, s_ready}, 32'd1);
    check("rst_done", {31'd0, s_done}, 32'd0);
    check("rst_own", {31'd0, s_own}, 32'd0);
    check("rst_result", s_result, 32'd0);
    check("rst_alu_op", {28'd0, s_op}, {28'd0, ALU_OP_ADD});
    check("rst_alu_opnd1", s_a1, 32'd0);
    check("rst_alu_opnd2", s_a2, 32'd0);
    run_op("remu_after_rst", OpRemu, 32'd1000, 32'd7, 32'd6, 33, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
